// File: rtl/alu_issue_pkg.sv
// Shared opcode map, FSM state encoding and per-opcode decode helpers
// for the ALU issue controller.
package alu_issue_pkg;

  localparam logic [5:0] OP_ADD = 6'b001001;
  localparam logic [5:0] OP_ADC = 6'b001010;
  localparam logic [5:0] OP_SUB = 6'b001011;
  localparam logic [5:0] OP_SBB = 6'b001100;
  localparam logic [5:0] OP_SHL = 6'b001101;
  localparam logic [5:0] OP_SHR = 6'b001110;
  localparam logic [5:0] OP_MOV = 6'b001111;
  localparam logic [5:0] OP_NEG = 6'b010000;
  localparam logic [5:0] OP_DIV = 6'b010001;
  localparam logic [5:0] OP_MOD = 6'b010010;
  localparam logic [5:0] OP_AND = 6'b010011;
  localparam logic [5:0] OP_OR  = 6'b010100;
  localparam logic [5:0] OP_XOR = 6'b010101;
  localparam logic [5:0] OP_NOT = 6'b010110;
  localparam logic [5:0] OP_CMP = 6'b010111;
  localparam logic [5:0] OP_TST = 6'b011000;
  localparam logic [5:0] OP_INC = 6'b011001;
  localparam logic [5:0] OP_DEC = 6'b011010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_DEC);
  endfunction

  function automatic logic writes_back(input logic [5:0] op);
    return op != OP_CMP;
  endfunction

  // Enable bits ordered {ZF,CF,NF,OF}, matching the flags status register.
  function automatic logic [3:0] op_flag_mask(input logic [5:0] op);
    logic [3:0] m;
    m = 4'b1000;
    if (((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_NEG) ||
        (op == OP_INC) || (op == OP_DEC))
      m = 4'b1111;
    else if (op == OP_CMP)
      m = 4'b1010;
    return m;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// NREGS x DW register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front end for the combinational ALU: IDLE -> EXEC -> DONE per instruction.
// Optional macro ALU_ISSUE_DIV0_TRAP_EN rejects DIV/MOD with a zero source operand.
//
// state | meaning
// IDLE  | ready; decode, read operands, issue to ALU or reject
// EXEC  | ALU settling; write back result and update flags on exit
// DONE  | one-cycle retire pulse
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [5:0]                 instr_op,
  input  logic [$clog2(NREGS)-1:0]   instr_rd,
  input  logic [$clog2(NREGS)-1:0]   instr_rs,
  input  logic                       instr_imm_en,
  input  logic [DW-1:0]              instr_imm,
  output logic [DW-1:0]              alu_a,
  output logic [DW-1:0]              alu_b,
  output logic [5:0]                 alu_opcode,
  input  logic [DW:0]                alu_result,
  input  logic                       alu_zf,
  input  logic                       alu_cf,
  input  logic                       alu_nf,
  input  logic                       alu_of,
  output logic                       done,
  output logic                       err,
  output logic [DW-1:0]              wb_data,
  output logic [3:0]                 flags,
  input  logic [$clog2(NREGS)-1:0]   dbg_addr,
  output logic [DW-1:0]              dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t        state, state_nx;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] rd_val, rs_val, src;
  logic          div0, reject, accept, reject_evt;
  logic          wb_en, flag_en;
  logic [3:0]    fmask;
  logic          unused_carry_bit;

  // Bit DW of the result is only ever observed through CF.
  assign unused_carry_bit = alu_result[DW];

  assign src = instr_imm_en ? instr_imm : rs_val;

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  assign div0 = ((instr_op == OP_DIV) || (instr_op == OP_MOD)) && (src == '0);
`else
  assign div0 = 1'b0;
`endif

  assign reject     = !is_legal(instr_op) || div0;
  assign accept     = (state == ST_IDLE) && instr_valid && !reject;
  assign reject_evt = (state == ST_IDLE) && instr_valid && reject;
  assign fmask      = op_flag_mask(alu_opcode);

  alu_issue_regfile #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_en),
    .waddr    (rd_q),
    .wdata    (alu_result[DW-1:0]),
    .raddr_a  (instr_rd),
    .rdata_a  (rd_val),
    .raddr_b  (instr_rs),
    .rdata_b  (rs_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    wb_en       = 1'b0;
    flag_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (accept) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        wb_en    = writes_back(alu_opcode);
        flag_en  = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      err        <= 1'b0;
      wb_data    <= '0;
      flags      <= '0;
    end else begin
      err <= reject_evt;
      if (accept) begin
        rd_q       <= instr_rd;
        alu_opcode <= instr_op;
        alu_b      <= src;
        alu_a      <= (instr_op == OP_MOV) ? src : rd_val;
      end
      if (wb_en) wb_data <= alu_result[DW-1:0];
      if (flag_en) begin
        if (fmask[3]) flags[3] <= alu_zf;
        if (fmask[2]) flags[2] <= alu_cf;
        if (fmask[1]) flags[1] <= alu_nf;
        if (fmask[0]) flags[0] <= alu_of;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the downstream side, array model
// of the register file and flags, directed plus random instruction streams.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  instr_op;
  logic [2:0]  instr_rd, instr_rs;
  logic        instr_imm_en;
  logic [15:0] instr_imm;
  logic [15:0] alu_a, alu_b;
  logic [5:0]  alu_opcode;
  logic [16:0] alu_result;
  logic        alu_zf, alu_cf, alu_nf, alu_of;
  logic        done, err;
  logic [15:0] wb_data;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] mr [8];
  logic [3:0]  mflags;
  logic [5:0]  mopc;
  int          last_acc;
  bit          prev_legal;

  alu_issue_ctrl #(.NREGS(8), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_nf(alu_nf), .alu_of(alu_of),
    .done(done), .err(err), .wb_data(wb_data), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {zf,cf,nf,of,result[16:0]}.
  function automatic logic [20:0] alu_f(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    logic        o;
    r = '0;
    o = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin r = {1'b0, a} + {1'b0, b}; o = (a[15] == b[15]) && (r[15] != a[15]); end
      OP_SUB, OP_SBB, OP_CMP: begin r = {1'b0, a} + {1'b0, ~b} + 17'd1; o = (a[15] != b[15]) && (r[15] != a[15]); end
      OP_SHL: r = {a, 1'b0};
      OP_SHR: r = {2'b00, a[15:1]};
      OP_MOV: r = {1'b0, b};
      OP_NEG: r = {1'b0, ~a} + 17'd1;
      OP_DIV: r = (b == 16'h0) ? 17'h1FFFF : {1'b0, a / b};
      OP_MOD: r = (b == 16'h0) ? {1'b0, a} : {1'b0, a % b};
      OP_AND, OP_TST: r = {1'b0, a & b};
      OP_OR:  r = {1'b0, a | b};
      OP_XOR: r = {1'b0, a ^ b};
      OP_NOT: r = {1'b0, ~a};
      OP_INC: begin r = {1'b0, a} + 17'd1; o = (a == 16'h7FFF); end
      OP_DEC: begin r = {1'b0, a} + 17'h1FFFF; o = (a == 16'h8000); end
      default: r = '0;
    endcase
    return {(r[15:0] == 16'h0), r[16], r[15], o, r};
  endfunction

  always_comb {alu_zf, alu_cf, alu_nf, alu_of, alu_result} = alu_f(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 16'h0;
    mflags     = 4'h0;
    mopc       = 6'h0;
    prev_legal = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic ie, input logic [15:0] imm);
    logic [15:0] src, a;
    logic [20:0] y;
    logic        legal, cnz;
    int          n, acc;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    chk("ready_idle", {31'h0, instr_ready}, 32'h1);
    chk("done_low_idle", {31'h0, done}, 32'h0);
    chk("err_low_idle", {31'h0, err}, 32'h0);
    src   = ie ? imm : mr[rs];
    legal = (op >= 6'd9) && (op <= 6'd26);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    if ((op == 6'd17 || op == 6'd18) && src == 16'h0) legal = 1'b0;
`endif
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs;
    instr_imm_en = ie; instr_imm = imm;
    acc = cyc;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op    = 6'h3F;
    dbg_addr    = rd;
    #1;
    if (!legal) begin
      chk("err_pulse", {31'h0, err}, 32'h1);
      chk("no_done_on_err", {31'h0, done}, 32'h0);
      chk("ready_after_err", {31'h0, instr_ready}, 32'h1);
      chk("opcode_not_issued", {26'h0, alu_opcode}, {26'h0, mopc});
      chk("flags_unchanged", {28'h0, flags}, {28'h0, mflags});
      chk("rd_unchanged", {16'h0, dbg_data}, {16'h0, mr[rd]});
      prev_legal = 1'b0;
    end else begin
      if (prev_legal) chk("accept_spacing", acc - last_acc, 32'd3);
      a = (op == OP_MOV) ? src : mr[rd];
      chk("err_low_exec", {31'h0, err}, 32'h0);
      chk("ready_low_exec", {31'h0, instr_ready}, 32'h0);
      chk("alu_opcode", {26'h0, alu_opcode}, {26'h0, op});
      chk("alu_a", {16'h0, alu_a}, {16'h0, a});
      chk("alu_b", {16'h0, alu_b}, {16'h0, src});
      chk("dbg_old_value", {16'h0, dbg_data}, {16'h0, mr[rd]});
      y = alu_f(op, a, src);
      if (op != OP_CMP) mr[rd] = y[15:0];
      mflags[3] = y[20];
      cnz = ((op >= 6'd9) && (op <= 6'd14)) || (op == 6'd16) || (op == 6'd25) || (op == 6'd26);
      if (cnz) mflags[2:0] = y[19:17];
      else if (op == OP_CMP) mflags[1] = y[18];
      mopc = op;
      @(negedge clk);
      #1;
      chk("done_pulse", {31'h0, done}, 32'h1);
      chk("ready_low_done", {31'h0, instr_ready}, 32'h0);
      if (op != OP_CMP) chk("wb_data", {16'h0, wb_data}, {16'h0, y[15:0]});
      chk("flags", {28'h0, flags}, {28'h0, mflags});
      chk("dbg_new_value", {16'h0, dbg_data}, {16'h0, mr[rd]});
      prev_legal = 1'b1;
      last_acc   = acc;
    end
  endtask

  task automatic peek(input string tag, input logic [2:0] r, input logic [15:0] exp);
    dbg_addr = r;
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  initial begin
    logic [5:0]  rop;
    logic [15:0] rimm;
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 6'h0; instr_rd = 3'h0;
    instr_rs = 3'h0; instr_imm_en = 1'b0; instr_imm = 16'h0; dbg_addr = 3'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_alu_a", {16'h0, alu_a}, 32'h0);
    chk("rst_alu_b", {16'h0, alu_b}, 32'h0);
    chk("rst_opcode", {26'h0, alu_opcode}, 32'h0);
    chk("rst_wb_data", {16'h0, wb_data}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'h0, instr_ready}, 32'h1);

    issue(OP_MOV, 3'd1, 3'd0, 1'b1, 16'h0011);
    issue(OP_MOV, 3'd2, 3'd0, 1'b1, 16'h0002);
    issue(OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0);
    chk("add_wb", {16'h0, wb_data}, 32'h0013);
    chk("add_flags", {28'h0, flags}, 32'h0);
    peek("add_r1", 3'd1, 16'h0013);

    issue(OP_MOV, 3'd3, 3'd0, 1'b1, 16'h7FFF);
    issue(OP_MOV, 3'd4, 3'd0, 1'b1, 16'h8001);
    issue(OP_SUB, 3'd3, 3'd4, 1'b0, 16'h0);
    chk("sub_flags", {28'h0, flags}, 32'h3);
    peek("sub_r3", 3'd3, 16'hFFFE);

    issue(OP_MOV, 3'd5, 3'd0, 1'b1, 16'h0005);
    issue(OP_CMP, 3'd5, 3'd0, 1'b1, 16'h0005);
    chk("cmp_flags", {28'h0, flags}, 32'h9);
    peek("cmp_r5", 3'd5, 16'h0005);

    issue(6'b111111, 3'd1, 3'd2, 1'b0, 16'h0);
    issue(6'b000000, 3'd2, 3'd1, 1'b1, 16'h1234);
    issue(OP_DIV, 3'd1, 3'd0, 1'b1, 16'h0000);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    peek("div0_r1_kept", 3'd1, 16'h0013);
`else
    peek("div0_r1_written", 3'd1, 16'hFFFF);
`endif
    issue(OP_MOD, 3'd3, 3'd2, 1'b1, 16'h0000);

    for (int k = 0; k < 48; k++) begin
      if (($urandom % 4) == 0) rop = 6'($urandom_range(0, 63));
      else                     rop = 6'($urandom_range(9, 26));
      rimm = (($urandom % 5) == 0) ? 16'h0 : 16'($urandom);
      issue(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom % 2), rimm);
    end
    for (int i = 0; i < 8; i++) peek("sweep", 3'(i), mr[i]);

    issue(OP_MOV, 3'd6, 3'd0, 1'b1, 16'hA5A5);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd6; instr_rs = 3'd6; instr_imm_en = 1'b0;
    @(posedge clk);
    #2;
    instr_valid = 1'b0;
    chk("exec_before_rst", {31'h0, instr_ready}, 32'h0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_exec_flags", {28'h0, flags}, 32'h0);
    chk("rst_exec_done", {31'h0, done}, 32'h0);
    peek("rst_exec_r6", 3'd6, 16'h0);
    @(negedge clk);
    #1;
    chk("rst_hold_done", {31'h0, done}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_first_edge", {31'h0, instr_ready}, 32'h1);
    chk("no_done_after_rst", {31'h0, done}, 32'h0);
    chk("no_err_after_rst", {31'h0, err}, 32'h0);
    for (int i = 0; i < 8; i++) peek("rst_sweep", 3'(i), 16'h0);
    issue(OP_INC, 3'd0, 3'd0, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
